// File: rtl/result_mux_pkg.sv
// Shared types and default sizing for the result mux pipeline.
package result_mux_pkg;
  localparam int DEF_WIDTH  = 32;
  localparam int DEF_NUM_IN = 5;
  localparam int DEF_CTL_W  = 4;

  typedef enum logic [1:0] {EMPTY = 2'd0, HALF = 2'd1, FULL = 2'd2} state_t;
endpackage

// File: rtl/result_sel.sv
// Combinational NUM_IN:1 channel select; out-of-range select yields zero.
module result_sel
  import result_mux_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int CTL_W  = DEF_CTL_W
) (
  input  logic [CTL_W-1:0]        i_ctl,
  input  logic [NUM_IN*WIDTH-1:0] i_data,
  output logic [WIDTH-1:0]        o_sel,
  output logic                    o_oor
);
  always_comb begin
    o_sel = '0;
    o_oor = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (i_ctl == CTL_W'(i)) begin
        o_sel = i_data[i*WIDTH +: WIDTH];
        o_oor = 1'b0;
      end
    end
  end
endmodule

// File: rtl/result_mux_pipe.sv
// Channel select feeding a two-entry (main + skid) output buffer with a
// sticky out-of-range select flag.
module result_mux_pipe
  import result_mux_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int CTL_W  = DEF_CTL_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CTL_W-1:0]        ctl,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out,
  output logic                    sel_err,
  input  logic                    err_clr
);
  if (NUM_IN < 2 || NUM_IN > 16 || CTL_W < $clog2(NUM_IN)) begin : g_param_chk
    $error("result_mux_pipe: illegal NUM_IN/CTL_W combination");
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             r_sel_err;
  logic [WIDTH-1:0] w_sel;
  logic             w_oor;
  logic             w_in_fire;
  logic             w_out_fire;

  result_sel #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .CTL_W(CTL_W)) u_sel (
    .i_ctl  (ctl),
    .i_data (data_in),
    .o_sel  (w_sel),
    .o_oor  (w_oor)
  );

  assign in_ready   = (r_state != FULL);
  assign out_valid  = (r_state != EMPTY);
  assign out        = r_main;
  assign sel_err    = r_sel_err;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= EMPTY;
      r_main    <= '0;
      r_skid    <= '0;
      r_sel_err <= 1'b0;
    end else begin
      // a coinciding out-of-range accept beats the clear
      if (w_in_fire && w_oor) r_sel_err <= 1'b1;
      else if (err_clr)       r_sel_err <= 1'b0;

      case (r_state)
        EMPTY: if (w_in_fire) begin
          r_main  <= w_sel;
          r_state <= HALF;
        end
        HALF: begin
          if (w_in_fire && w_out_fire) begin
            r_main <= w_sel;
          end else if (w_in_fire) begin
            r_skid  <= w_sel;
            r_state <= FULL;
          end else if (w_out_fire) begin
            // main is cleared so out reads zero while empty
            r_main  <= '0;
            r_state <= EMPTY;
          end
        end
        FULL: if (w_out_fire) begin
          r_main  <= r_skid;
          r_state <= HALF;
        end
        default: r_state <= EMPTY;
      endcase
    end
  end
endmodule
